// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing FSM for the floating-point multiplier datapath.
// It walks the datapath through operand load, special-operand check, exponent
// setup, the multi-cycle mantissa multiply, normalise, round and result load.
// Each pipeline register gets a single one-cycle load enable per operation.
// Operands that are zero/inf/NaN skip straight from the check to the result
// stage, and the result mux is steered onto the special-value path.
//
// Handshake with the FPU top-level control:
//   beg_fsm is a start request and is only sampled in IDLE. A request seen in
//   any other state is dropped and is not queued.
//   ready_o rises when the result register is valid. It stays high until
//   ack_fsm is sampled in DONE, and the FSM then returns to IDLE.
//   ack_fsm is ignored outside DONE.
//   A beg_fsm that coincides with the ack is ignored. A new start must always
//   be sampled in IDLE, so there is at least one idle cycle between operations.
//
// The load enables, busy_o and ready_o are Moore outputs decoded from state_q.
// The asynchronous reset therefore clears every one of them at the moment rst
// rises.
module mult_seq_ctrl #(
  parameter int MUL_LAT = 4,  // multiplier cycles after operands are stable (>=1)
  parameter int CNT_W   = 3   // wait counter width, 2**CNT_W >= MUL_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic beg_fsm,
  input  logic ack_fsm,
  input  logic special_i,
  input  logic norm_i,
  input  logic ovf_i,
  input  logic unf_i,
  output logic load_op_o,
  output logic load_exp_o,
  output logic load_mul_o,
  output logic load_norm_o,
  output logic load_rnd_o,
  output logic load_res_o,
  output logic shift_o,
  output logic special_sel_o,
  output logic busy_o,
  output logic ready_o,
  output logic ovf_flag_o,
  output logic unf_flag_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD_OP  = 4'd1,
    S_CHK      = 4'd2,
    S_EXP      = 4'd3,
    S_MUL_WAIT = 4'd4,
    S_NORM     = 4'd5,
    S_RND      = 4'd6,
    S_RES      = 4'd7,
    S_DONE     = 4'd8
  } state_e;

  // The counter is preloaded with MUL_LAT-1 and counts down to zero, so the
  // FSM spends exactly MUL_LAT cycles in MUL_WAIT.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             special_q, special_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // State, wait counter, special latch and sticky flags; async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      special_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Next-state logic and Moore output decode; every output defaults low first.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    special_d     = special_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    load_op_o     = 1'b0;
    load_exp_o    = 1'b0;
    load_mul_o    = 1'b0;
    load_norm_o   = 1'b0;
    load_rnd_o    = 1'b0;
    load_res_o    = 1'b0;
    shift_o       = 1'b0;
    special_sel_o = 1'b0;
    busy_o        = 1'b1;
    ready_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (beg_fsm) begin
          state_d = S_LOAD_OP;
        end
      end

      S_LOAD_OP: begin
        // A new operation starts here, so the previous result's flags and
        // special selection are discarded.
        load_op_o = 1'b1;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        special_d = 1'b0;
        state_d   = S_CHK;
      end

      S_CHK: begin
        // special_i comes from the operand registers loaded in the previous
        // cycle.
        special_sel_o = special_q;
        if (special_i) begin
          special_d = 1'b1;
          state_d   = S_RES;
        end else begin
          state_d = S_EXP;
        end
      end

      S_EXP: begin
        special_sel_o = special_q;
        load_exp_o    = 1'b1;
        cnt_d         = LAT_M1;
        state_d       = S_MUL_WAIT;
      end

      S_MUL_WAIT: begin
        special_sel_o = special_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          load_mul_o = 1'b1;
          state_d    = S_NORM;
        end
      end

      S_NORM: begin
        special_sel_o = special_q;
        load_norm_o   = 1'b1;
        shift_o       = norm_i;
        state_d       = S_RND;
      end

      S_RND: begin
        special_sel_o = special_q;
        load_rnd_o    = 1'b1;
        state_d       = S_RES;
      end

      S_RES: begin
        // The exponent flags mean nothing for a special result, so they are
        // forced to zero on that path.
        special_sel_o = special_q;
        load_res_o    = 1'b1;
        if (special_q) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end else begin
          ovf_d = ovf_i;
          unf_d = unf_i;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        special_sel_o = special_q;
        ready_o       = 1'b1;
        if (ack_fsm) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        // Any unused encoding falls back to IDLE on the next clock, with all
        // outputs held low.
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign ovf_flag_o = ovf_q;
  assign unf_flag_o = unf_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed bench for mult_seq_ctrl.
// There are three instances, with MUL_LAT = 4, 1 and 8. Each one has its own
// beg/ack lines and all of them share the data-side inputs.
// When a driver task starts an operation it pushes the expected event trace
// onto that instance's queue. Each queue entry holds the event kind, the
// absolute cycle and a small data field.
// A negedge monitor turns the outputs of each instance into events. It pops
// the matching queue entry and compares them.
module tb_mult_seq_ctrl;

  localparam int W = 23;  // {kind[3:0], cycle[15:0], data[2:0]}
  localparam int N = 3;

  // event kinds
  localparam logic [3:0] K_OP   = 4'd1;
  localparam logic [3:0] K_EXP  = 4'd2;
  localparam logic [3:0] K_MUL  = 4'd3;
  localparam logic [3:0] K_NORM = 4'd4;
  localparam logic [3:0] K_RND  = 4'd5;
  localparam logic [3:0] K_RES  = 4'd6;
  localparam logic [3:0] K_RDY  = 4'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [N-1:0] beg, ack;
  logic         special_in, norm_in, ovf_in, unf_in;
  logic [N-1:0] load_op, load_exp, load_mul, load_norm, load_rnd, load_res;
  logic [N-1:0] shift, special_sel, busy, ready, ovf_flag, unf_flag;
  logic [13:0]  all_out [N];

  mult_seq_ctrl #(.MUL_LAT(4), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .beg_fsm(beg[0]), .ack_fsm(ack[0]),
    .special_i(special_in), .norm_i(norm_in), .ovf_i(ovf_in), .unf_i(unf_in),
    .load_op_o(load_op[0]), .load_exp_o(load_exp[0]), .load_mul_o(load_mul[0]),
    .load_norm_o(load_norm[0]), .load_rnd_o(load_rnd[0]), .load_res_o(load_res[0]),
    .shift_o(shift[0]), .special_sel_o(special_sel[0]), .busy_o(busy[0]),
    .ready_o(ready[0]), .ovf_flag_o(ovf_flag[0]), .unf_flag_o(unf_flag[0])
  );

  mult_seq_ctrl #(.MUL_LAT(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .beg_fsm(beg[1]), .ack_fsm(ack[1]),
    .special_i(special_in), .norm_i(norm_in), .ovf_i(ovf_in), .unf_i(unf_in),
    .load_op_o(load_op[1]), .load_exp_o(load_exp[1]), .load_mul_o(load_mul[1]),
    .load_norm_o(load_norm[1]), .load_rnd_o(load_rnd[1]), .load_res_o(load_res[1]),
    .shift_o(shift[1]), .special_sel_o(special_sel[1]), .busy_o(busy[1]),
    .ready_o(ready[1]), .ovf_flag_o(ovf_flag[1]), .unf_flag_o(unf_flag[1])
  );

  mult_seq_ctrl #(.MUL_LAT(8), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .beg_fsm(beg[2]), .ack_fsm(ack[2]),
    .special_i(special_in), .norm_i(norm_in), .ovf_i(ovf_in), .unf_i(unf_in),
    .load_op_o(load_op[2]), .load_exp_o(load_exp[2]), .load_mul_o(load_mul[2]),
    .load_norm_o(load_norm[2]), .load_rnd_o(load_rnd[2]), .load_res_o(load_res[2]),
    .shift_o(shift[2]), .special_sel_o(special_sel[2]), .busy_o(busy[2]),
    .ready_o(ready[2]), .ovf_flag_o(ovf_flag[2]), .unf_flag_o(unf_flag[2])
  );

  always_comb begin
    for (int k = 0; k < N; k++) begin
      all_out[k] = {load_op[k], load_exp[k], load_mul[k], load_norm[k], load_rnd[k],
                    load_res[k], shift[k], special_sel[k], busy[k], ready[k],
                    ovf_flag[k], unf_flag[k], 2'b00};
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int k, input logic [3:0] kind, input int at,
                          input logic [2:0] data);
    logic [W-1:0] e;
    e = {kind, 16'(at), data};
    case (k)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(input int k, input logic [W-1:0] got);
    logic [W-1:0] e;
    int           sz;
    case (k)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    checks++;
    if (sz == 0) begin
      errors++;
      $display("FAIL evt%0d unexpected: got kind %0d cycle %0d data %0h, expected none",
               k, got[W-1:W-4], got[18:3], got[2:0]);
    end else begin
      case (k)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      if (got !== e) begin
        errors++;
        $display("FAIL evt%0d: got kind %0d cycle %0d data %0h, expected kind %0d cycle %0d data %0h",
                 k, got[W-1:W-4], got[18:3], got[2:0], e[W-1:W-4], e[18:3], e[2:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [N-1:0] rdy_prev = '0;

  task automatic mon_evt(input int k);
    logic [5:0]   loads;
    logic         rise;
    logic [3:0]   kind;
    logic [2:0]   data;
    int           n;
    loads = {load_res[k], load_rnd[k], load_norm[k], load_mul[k], load_exp[k], load_op[k]};
    rise  = ready[k] & ~rdy_prev[k];
    n     = $countones({loads, rise});
    kind  = 4'd0;
    data  = 3'd0;
    if (shift[k] && !load_norm[k]) chk("shift_outside_norm", 32'(shift[k]), 32'd0);
    if (n != 0) begin
      chk("one_event_per_cycle", 32'(n), 32'd1);
      if (rise) begin
        kind = K_RDY;
        data = {special_sel[k], ovf_flag[k], unf_flag[k]};
      end else begin
        for (int b = 0; b < 6; b++) if (loads[b]) kind = 4'(b + 1);
        if (kind == K_NORM) data = {2'b00, shift[k]};
      end
      pop_cmp(k, {kind, 16'(cyc), data});
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst) mon_evt(k);
      rdy_prev[k] <= ready[k];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Runs one operation on instance k (multiplier latency lat). The expected
  // offsets come from counting the cycles after the edge that samples beg.
  // Normal path: op@1, exp@3, mul@lat+3, norm@lat+4, rnd@lat+5, res@lat+6, ready@lat+7.
  // Special path: op@1, res@3, ready@4.
  task automatic run_op(input int k, input int lat, input bit sp, input bit nm,
                        input bit ov, input bit un, input int hold,
                        input bit mid_beg, input bit ack_with_beg);
    int         base;
    bit         got_rdy;
    logic [1:0] fl;
    fl = sp ? 2'b00 : {ov, un};
    step();
    special_in = sp;
    norm_in    = nm;
    ovf_in     = ov;
    unf_in     = un;
    base       = cyc;
    beg[k]     = 1'b1;
    push_exp(k, K_OP, base + 1, 3'b000);
    if (sp) begin
      push_exp(k, K_RES, base + 3, 3'b000);
      push_exp(k, K_RDY, base + 4, 3'b100);
    end else begin
      push_exp(k, K_EXP,  base + 3,       3'b000);
      push_exp(k, K_MUL,  base + lat + 3, 3'b000);
      push_exp(k, K_NORM, base + lat + 4, {2'b00, nm});
      push_exp(k, K_RND,  base + lat + 5, 3'b000);
      push_exp(k, K_RES,  base + lat + 6, 3'b000);
      push_exp(k, K_RDY,  base + lat + 7, {1'b0, ov, un});
    end
    got_rdy = 1'b0;
    for (int i = 1; i <= 40 && !got_rdy; i++) begin
      step();
      if (i == 1) beg[k] = 1'b0;
      if (i == 2) chk("flags_cleared_after_load_op", 32'({ovf_flag[k], unf_flag[k]}), 32'd0);
      if (mid_beg && i == 4) beg[k] = 1'b1;
      if (mid_beg && i == 5) beg[k] = 1'b0;
      if (ready[k]) got_rdy = 1'b1;
    end
    if (!got_rdy) chk("ready_timeout", 32'd0, 32'd1);
    for (int j = 0; j < hold; j++) begin
      chk("ready_held", 32'(ready[k]), 32'd1);
      chk("flags_held_done", 32'({ovf_flag[k], unf_flag[k]}), 32'(fl));
      step();
    end
    ack[k] = 1'b1;
    if (ack_with_beg) beg[k] = 1'b1;
    step();
    ack[k] = 1'b0;
    beg[k] = 1'b0;
    chk("idle_after_ack", 32'({ready[k], busy[k], special_sel[k]}), 32'd0);
    chk("flags_held_idle", 32'({ovf_flag[k], unf_flag[k]}), 32'(fl));
    step();
    chk("no_start_after_ack", 32'(busy[k]), 32'd0);
  endtask

  // Starts a normal op on dut0 (MUL_LAT=4) and resets during MUL_WAIT (cycle 5).
  task automatic reset_mid_op();
    int base;
    step();
    special_in = 1'b0;
    base       = cyc;
    beg[0]     = 1'b1;
    push_exp(0, K_OP,  base + 1, 3'b000);
    push_exp(0, K_EXP, base + 3, 3'b000);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) beg[0] = 1'b0;
    end
    chk("busy_in_mul_wait", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    exp_q0.delete();
    #1;
    chk("all_zero_on_rst", 32'(all_out[0]), 32'd0);
    step();
    chk("all_zero_during_rst", 32'(all_out[0]), 32'd0);
    step();
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    beg        = '0;
    ack        = '0;
    special_in = 1'b0;
    norm_in    = 1'b0;
    ovf_in     = 1'b0;
    unf_in     = 1'b0;
    step();
    step();
    for (int k = 0; k < N; k++) chk("reset_outputs", 32'(all_out[k]), 32'd0);
    rst = 1'b0;
    step();
    for (int k = 0; k < N; k++) chk("idle_outputs", 32'(all_out[k]), 32'd0);

    // normal, shift needed, immediate ack
    run_op(0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // overflow, no shift, 20-cycle ack hold, beg pulse in MUL_WAIT
    run_op(0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 20, 1'b1, 1'b0);
    // underflow, ack together with beg
    run_op(0, 4, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    // special path with ovf_i high: flags forced to zero
    run_op(0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    // reset in the middle, then a clean sequence
    reset_mid_op();
    run_op(0, 4, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    // latency sweep
    run_op(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    run_op(2, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    run_op(2, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    step();
    chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
    chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
    chk("queue2_drained", 32'(exp_q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
